// File: rtl/fsmd_arbiter.sv
// Round-robin arbiter that time-shares one fsmd datapath between NREQ requesters,
// with a watchdog that turns a hung transaction into an error response.
module fsmd_arbiter #(
   parameter int NREQ    = 4,
   parameter int IDW     = 2,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [4*NREQ-1:0] req_x,
   input  logic [4*NREQ-1:0] req_y,
   output logic [NREQ-1:0]   gnt,
   output logic              dp_start,
   output logic [3:0]        dp_xin,
   output logic [3:0]        dp_yin,
   input  logic              dp_idle,
   input  logic              dp_done,
   input  logic [7:0]        dp_x,
   output logic              rsp_valid,
   output logic [IDW-1:0]    rsp_id,
   output logic [7:0]        rsp_data,
   output logic              rsp_err,
   output logic              busy,
   output logic [7:0]        err_count
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

   state_t         state;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] cur_id;
   logic [TW-1:0]  timer;
   logic           done_q;
   logic           found;
   logic [IDW-1:0] pick;
   logic           complete;
   logic           expire;

   // Scan ptr+1, ptr+2, ... mod NREQ; the first set request wins.
   always_comb begin : rr_scan
      int unsigned    idx;
      logic [IDW-1:0] sel;
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      sel   = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx = (k + 32'(ptr)) % NREQ;
         sel = IDW'(idx);
         if (!found && req[sel]) begin
            found = 1'b1;
            pick  = sel;
         end
      end
   end

   always_comb begin
      complete = (state == WAIT) && dp_done && !done_q;
      expire   = ((state == LAUNCH) || (state == WAIT)) &&
                 (timer == TW'(TIMEOUT - 1)) && !complete;
      busy     = (state != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         gnt       <= '0;
         dp_start  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         dp_xin    <= '0;
         dp_yin    <= '0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         err_count <= '0;
         ptr       <= IDW'(NREQ - 1);
         cur_id    <= '0;
         timer     <= '0;
         done_q    <= 1'b1;
      end else begin
         done_q    <= dp_done;
         gnt       <= '0;
         dp_start  <= 1'b0;
         rsp_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (found) begin
                  gnt[pick] <= 1'b1;
                  dp_xin    <= 4'(req_x >> {pick, 2'b00});
                  dp_yin    <= 4'(req_y >> {pick, 2'b00});
                  ptr       <= pick;
                  cur_id    <= pick;
                  timer     <= '0;
                  state     <= LAUNCH;
               end
            end
            LAUNCH: begin
               timer <= timer + 1'b1;
               if (dp_idle) begin
                  dp_start <= 1'b1;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               timer <= timer + 1'b1;
            end
            RESP: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // Response capture overrides the LAUNCH/WAIT assignments above;
         // completion has priority over watchdog expiry.
         if (complete) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= dp_x;
            rsp_id    <= cur_id;
            state     <= RESP;
         end else if (expire) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            rsp_id    <= cur_id;
            dp_start  <= 1'b0;
            state     <= RESP;
            if (err_count != 8'hFF) begin
               err_count <= err_count + 8'd1;
            end
         end
      end
   end

endmodule

// File: doc/fsmd_arbiter.md
Name: fsmd_arbiter

Overview:
Round-robin arbiter and sequencer that shares one fsmd compute datapath between NREQ requesters. It accepts operand pairs, launches the datapath with a one-cycle start pulse and waits for a done rising edge. It then returns the 8-bit result, tagged with the requester id, on a shared response bus. A watchdog aborts hung transactions with an error response.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of rsp_id, equals ceil(log2(NREQ))
TIMEOUT, 16, maximum cycles spent in LAUNCH+WAIT before abort (≥8)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
req  in  NREQ  per-requester request level
req_x  in  4*NREQ  xin operand; requester i uses bits [4i+3:4i]
req_y  in  4*NREQ  yin operand; same packing
gnt  out  NREQ  one-hot grant pulse, one cycle; operands captured on the edge that raises it
dp_start  out  1  start pulse to datapath
dp_xin  out  4  latched x operand to datapath
dp_yin  out  4  latched y operand to datapath
dp_idle  in  1  datapath idle flag
dp_done  in  1  datapath done flag (level, stays high until next start)
dp_x  in  8  datapath result
rsp_valid  out  1  one-cycle response strobe
rsp_id  out  IDW  requester index of the response
rsp_data  out  8  result; 0 on error
rsp_err  out  1  set with rsp_valid when the watchdog fired
busy  out  1  combinational, high when state != IDLE
err_count  out  8  saturating count of watchdog aborts

Behaviour:
- Reset (async): state IDLE; gnt, dp_start, rsp_valid, rsp_err = 0; dp_xin, dp_yin, rsp_id, rsp_data, err_count = 0; rr pointer = NREQ-1 (requester 0 first); done_q = 1, so a stuck-high dp_done is not seen as an edge. A reset mid-transaction drops it with no response.
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE: if any req bit is set, pick the first set index scanning ptr+1, ptr+2, ... mod NREQ. On that edge: gnt[i]<=1, latch req_x/req_y slice into dp_xin/dp_yin, store id, ptr<=i, timer<=0, go to LAUNCH. If no req, stay.
- gnt is high exactly one cycle (the first LAUNCH cycle). Requesters must drop req on seeing gnt; a held req is treated as a new request and served again in round-robin order.
- LAUNCH: timer increments each cycle. When dp_idle=1, assert dp_start for one cycle (registered) and go to WAIT. dp_xin/dp_yin stay constant from the grant until the return to IDLE.
- WAIT: timer increments. Completion = dp_done & ~done_q, where done_q is dp_done registered every cycle. On completion, capture dp_x into rsp_data, set rsp_err<=0, rsp_valid<=1, go to RESP.
- Watchdog: if timer == TIMEOUT-1 in LAUNCH or WAIT with no completion that cycle, then rsp_valid<=1, rsp_err<=1, rsp_data<=0, err_count+1 (saturating at 255), dp_start forced 0, go to RESP. If completion and expiry occur in the same cycle, completion wins.
- RESP: rsp_valid is high for this one cycle with rsp_id; it is cleared next cycle and state returns to IDLE. rsp_data/rsp_id/rsp_err hold until the next response.
- Latency with a sole requester and a 4-state fsmd datapath:
  - req sampled in cycle N
  - gnt in N+1
  - dp_start in N+2
  - dp_done rises in N+6
  - rsp_valid in N+7
  - IDLE in N+8; next grant is possible in N+9.
- No grant is issued while busy; requests arriving meanwhile wait and are resolved by round-robin in IDLE.

Test Plan:
- Reset, then req[0] with x=6, y=9 -> gnt=0001 in N+1, dp_start in N+2, rsp_valid in N+7 with rsp_id=0, rsp_data=4, rsp_err=0.
- req[1] with x=1, y=15 -> rsp_data=251 (8-bit wrap of 0-5), rsp_id=1.
- req=1111 held continuously, all x=3, y=9 -> grants in order 0,1,2,3,0, each rsp_data=2, one grant per 8 cycles, gnt always one-hot.
- Datapath model with dp_done tied 0 -> rsp_valid with rsp_err=1 and rsp_data=0, TIMEOUT cycles after LAUNCH entry; err_count=1; next request served normally.
- dp_idle held 0 for 20 cycles -> no dp_start, timeout error response, busy deasserts after RESP.
- rst pulsed in WAIT -> all outputs 0 immediately, no rsp_valid; next req[2] is granted first among pending requests 2 and 3.
